// File: rtl/seq_pattern_gen_if.sv
// Bus bundle for seq_pattern_gen: transfer request/config inputs and serial outputs.
interface seq_pattern_gen_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
);
  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             data_out;
  logic             data_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic             err;

  // Requester side: drives the transfer request, observes the serial line.
  modport master (
    output start, pattern, pat_len, repeat_cnt, gap, abort,
    input  data_out, data_valid, frame_start, busy, done, err
  );

  // Generator side.
  modport slave (
    input  start, pattern, pat_len, repeat_cnt, gap, abort,
    output data_out, data_valid, frame_start, busy, done, err
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a 1..PAT_W bit pattern MSB-first, one bit
// per clock, repeated repeat_cnt+1 times with gap idle cycles between repetitions.
// Optional feature macro: SEQ_PATTERN_GEN_LFSR_FILL_EN (LFSR noise on data_out in gaps).
module seq_pattern_gen #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_left;
  logic             data_out_q;
  logic             data_valid_q;
  logic             frame_start_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             len_bad_c;
  logic [IDX_W-1:0] len_idx_c;
  logic             rep_end_c;
  logic             more_c;
  logic             fill_c;

  assign len_bad_c = (bus.pat_len == '0) || (bus.pat_len > LEN_W'(PAT_W));
  assign len_idx_c = IDX_W'(bus.pat_len - LEN_W'(1));
  assign rep_end_c = (bit_idx == '0);
  assign more_c    = (rep_left != '0);

`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
  logic [7:0] lfsr;
  logic       fill_adv_c;

  // LFSR steps on every edge that loads a gap cycle onto data_out.
  assign fill_c     = lfsr[7];
  assign fill_adv_c = !bus.abort &&
                      (((state == SEND) && rep_end_c && more_c && (gap_q != '0)) ||
                       ((state == GAP) && (gap_left != GAP_W'(1))));

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed A5.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (fill_adv_c) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  assign fill_c = 1'b0;
`endif

  // Transfer FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pat_q         <= '0;
      first_idx     <= '0;
      bit_idx       <= '0;
      rep_left      <= '0;
      gap_q         <= '0;
      gap_left      <= '0;
      data_out_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (len_bad_c) begin
              err_q <= 1'b1;
            end else begin
              state         <= SEND;
              pat_q         <= bus.pattern;
              first_idx     <= len_idx_c;
              bit_idx       <= len_idx_c;
              rep_left      <= bus.repeat_cnt;
              gap_q         <= bus.gap;
              data_out_q    <= bus.pattern[len_idx_c];
              data_valid_q  <= 1'b1;
              frame_start_q <= 1'b1;
              busy_q        <= 1'b1;
            end
          end
        end
        SEND: begin
          if (bus.abort) begin
            state        <= IDLE;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (!rep_end_c) begin
            bit_idx    <= bit_idx - IDX_W'(1);
            data_out_q <= pat_q[bit_idx - IDX_W'(1)];
          end else if (more_c) begin
            rep_left <= rep_left - CNT_W'(1);
            if (gap_q != '0) begin
              state        <= GAP;
              gap_left     <= gap_q;
              data_out_q   <= fill_c;
              data_valid_q <= 1'b0;
            end else begin
              bit_idx       <= first_idx;
              data_out_q    <= pat_q[first_idx];
              frame_start_q <= 1'b1;
            end
          end else begin
            state        <= IDLE;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        GAP: begin
          if (bus.abort) begin
            state        <= IDLE;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (gap_left == GAP_W'(1)) begin
            state         <= SEND;
            bit_idx       <= first_idx;
            data_out_q    <= pat_q[first_idx];
            data_valid_q  <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            gap_left   <= gap_left - GAP_W'(1);
            data_out_q <= fill_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: table of whole transfers plus hand-written
// sequences for error, abort, reset, back-to-back and max-repeat cases.
module tb_seq_pattern_gen;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] lfsr_m;

  seq_pattern_gen_if bus ();

  seq_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected streams are written in time order: cycle c of n is bit [n-c].
  typedef struct packed {
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [7:0]  rep;
    logic [3:0]  gap;
    logic [5:0]  n;
    logic [31:0] d;
    logic [31:0] v;
    logic [31:0] f;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  // Output order: {data_out, data_valid, frame_start, busy, done, err}
  function automatic logic [5:0] outs();
    return {bus.data_out, bus.data_valid, bus.frame_start, bus.busy, bus.done, bus.err};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    lfsr_m = 8'hA5;
    tick();
  endtask

  // Pulse start with the given config; returns 1ns after the capturing edge.
  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r,
                        input logic [3:0] g);
    @(negedge clk);
    bus.pattern    = p;
    bus.pat_len    = l;
    bus.repeat_cnt = r;
    bus.gap        = g;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    logic [5:0] e;
    int n;
    n = int'(t.n);
    launch(t.pattern, t.len, t.rep, t.gap);
    for (int c = 1; c <= n + 2; c++) begin
      if (c > 1) tick();
      if (c == 1) begin
        bus.pattern    = ~t.pattern;
        bus.pat_len    = 4'd2;
        bus.repeat_cnt = 8'd5;
        bus.gap        = 4'd3;
      end
      if (c <= n) begin
        e = {t.d[n-c], t.v[n-c], t.f[n-c], 1'b1, 1'b0, 1'b0};
        if (!t.v[n-c]) begin
`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
          e[5] = lfsr_m[7];
          lfsr_m = lfsr_step(lfsr_m);
`else
          e[5] = 1'b0;
`endif
        end
      end else if (c == n + 1) begin
        e = 6'b000010;
      end else begin
        e = 6'b000000;
      end
      check($sformatf("vec%0d_cyc%0d", idx, c), outs(), e);
    end
  endtask

  initial begin
    int cnt;
    bit seen_done;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    lfsr_m = 8'hA5;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pattern = '0;
    bus.pat_len = '0;
    bus.repeat_cnt = '0;
    bus.gap = '0;

    vecs[0] = '{8'b101,      4'd3, 8'd0, 4'd0, 6'd3,  32'b101,        32'b111,        32'b100};
    vecs[1] = '{8'b101,      4'd3, 8'd2, 4'd0, 6'd9,  32'b101101101,  32'b111111111,  32'b100100100};
    vecs[2] = '{8'b1101,     4'd4, 8'd1, 4'd2, 6'd10, 32'b1101001101, 32'b1111001111, 32'b1000001000};
    vecs[3] = '{8'b1,        4'd1, 8'd1, 4'd1, 6'd3,  32'b101,        32'b101,        32'b101};
    vecs[4] = '{8'hC5,       4'd8, 8'd0, 4'd0, 6'd8,  32'b11000101,   32'b11111111,   32'b10000000};
    vecs[5] = '{8'hF2,       4'd3, 8'd0, 4'd0, 6'd3,  32'b010,        32'b111,        32'b100};
    vecs[6] = '{8'b10,       4'd2, 8'd2, 4'd1, 6'd8,  32'b10010010,   32'b11011011,   32'b10010010};

    // Reset state
    tick();
    tick();
    check("reset", outs(), 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_after_reset", outs(), 6'b000000);

    // Table of complete transfers
    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Illegal lengths: err pulse only
    launch(8'hFF, 4'd0, 8'd0, 4'd0);
    check("err_len0", outs(), 6'b000001);
    tick();
    check("err_len0_clear", outs(), 6'b000000);
    launch(8'hFF, 4'd9, 8'd0, 4'd0);
    check("err_len9", outs(), 6'b000001);
    tick();
    check("err_len9_clear", outs(), 6'b000000);

    // abort together with start in IDLE: nothing happens
    @(negedge clk);
    bus.abort = 1'b1;
    launch(8'b101, 4'd3, 8'd0, 4'd0);
    bus.abort = 1'b0;
    check("abort_start_idle", outs(), 6'b000000);
    tick();
    check("abort_start_idle_2", outs(), 6'b000000);

    // abort mid-transfer: line drops next cycle, no done
    launch(8'b101, 4'd3, 8'd0, 4'd0);
    check("abort_c1", outs(), 6'b111100);
    tick();
    check("abort_c2", outs(), 6'b010100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_c3", outs(), 6'b000000);
    tick();
    check("abort_c4_no_done", outs(), 6'b000000);

    // start while busy is ignored
    launch(8'b101, 4'd3, 8'd0, 4'd0);
    check("busy_start_c1", outs(), 6'b111100);
    bus.pattern = 8'h00;
    bus.pat_len = 4'd3;
    bus.start = 1'b1;
    tick();
    check("busy_start_c2", outs(), 6'b010100);
    tick();
    bus.start = 1'b0;
    check("busy_start_c3", outs(), 6'b110100);
    tick();
    check("busy_start_c4_done", outs(), 6'b000010);
    tick();
    check("busy_start_c5", outs(), 6'b000000);

    // start in the done cycle is accepted back-to-back
    launch(8'b101, 4'd3, 8'd0, 4'd0);
    tick();
    tick();
    tick();
    check("chain_done", outs(), 6'b000010);
    bus.pattern = 8'b011;
    bus.pat_len = 4'd3;
    bus.repeat_cnt = 8'd0;
    bus.gap = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("chain_c1", outs(), 6'b011100);
    tick();
    check("chain_c2", outs(), 6'b110100);
    tick();
    check("chain_c3", outs(), 6'b110100);
    tick();
    check("chain_done2", outs(), 6'b000010);

    // rst mid-transfer clears everything, then a fresh transfer works
    launch(8'b101, 4'd3, 8'd2, 4'd0);
    tick();
    rst = 1'b1;
    lfsr_m = 8'hA5;
    tick();
    check("rst_mid", outs(), 6'b000000);
    rst = 1'b0;
    tick();
    check("rst_mid_no_done", outs(), 6'b000000);
    run_vec(100, vecs[0]);

    // repeat_cnt all-ones: 256 single-bit repetitions, then done
    launch(8'b1, 4'd1, 8'hFF, 4'd0);
    cnt = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      if (c > 0) tick();
      if (bus.done) seen_done = 1'b1;
      else if (bus.data_valid) cnt++;
    end
    check("maxrep_done_seen", {5'd0, seen_done}, 6'b000001);
    check("maxrep_count", 6'(cnt >> 3), 6'd32);
    check("maxrep_count_lsb", 6'(cnt & 7), 6'd0);
    tick();
    check("maxrep_idle", outs(), 6'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
